// File: rtl/fft_bin_streamer_if.sv
// Bus between the FFT result RAM, the bin streamer and the magnitude stage.
// The master modport is the streamer; the slave modport is the RAM/consumer side.
interface fft_bin_streamer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10
);
  logic                    i_fft_done;
  logic                    i_stall;
  logic                    o_rd_en;
  logic [ADDR_WIDTH-1:0]   o_rd_addr;
  logic [2*DATA_WIDTH-1:0] i_rd_data;
  logic [2*DATA_WIDTH-1:0] o_fft_complex;
  logic                    o_start;
  logic [ADDR_WIDTH-2:0]   o_bin_index;
  logic                    o_last;
  logic                    o_busy;
  logic                    o_frame_done;
  logic                    o_overrun;

  modport master (
    input  i_fft_done, i_stall, i_rd_data,
    output o_rd_en, o_rd_addr, o_fft_complex, o_start, o_bin_index,
           o_last, o_busy, o_frame_done, o_overrun
  );

  modport slave (
    output i_fft_done, i_stall, i_rd_data,
    input  o_rd_en, o_rd_addr, o_fft_complex, o_start, o_bin_index,
           o_last, o_busy, o_frame_done, o_overrun
  );
endinterface

// File: rtl/fft_bin_streamer.sv
// Streams bins 0..FFT_POINTS/2-1 of a finished FFT frame from RAM to the magnitude stage.
// Define FFT_BIT_REVERSE_EN when the RAM holds results in bit-reversed order.
module fft_bin_streamer #(
  parameter int DATA_WIDTH = 24,
  parameter int FFT_POINTS = 1024,
  parameter int ADDR_WIDTH = $clog2(FFT_POINTS)
) (
  input  logic               clk,
  input  logic               reset,
  fft_bin_streamer_if.master bus
);
  localparam int BW = ADDR_WIDTH - 1;
  localparam int CW = 2 * DATA_WIDTH;
  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_POINTS / 2 - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   rd_idx_q, rd_idx_d;
  logic            rd_pend_q, rd_pend_d;
  logic            skid_full_q, skid_full_d;
  logic [CW-1:0]   skid_data_q, skid_data_d;
  logic [BW-1:0]   emit_idx_q, emit_idx_d;
  logic [CW-1:0]   data_q, data_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic            start_q, start_d;
  logic            last_q, last_d;
  logic            frame_done_q, frame_done_d;
  logic            overrun_q, overrun_d;

  logic                  rd_en;
  logic                  busy;
  logic                  emit;
  logic [ADDR_WIDTH-1:0] nat_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign nat_addr = {1'b0, rd_idx_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_fft_done)                  state_d = READ;
      READ:    if (rd_en && (rd_idx_q == LAST_BIN)) state_d = DRAIN;
      DRAIN:   if (last_q)                          state_d = IDLE;
      default:                                      state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (state_q == READ) && !bus.i_stall;
    busy    = (state_q != IDLE);
    rd_addr = '0;
`ifdef FFT_BIT_REVERSE_EN
    for (int i = 0; i < ADDR_WIDTH; i++) rd_addr[i] = nat_addr[ADDR_WIDTH-1-i];
`else
    rd_addr = nat_addr;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_idx_d     = rd_en ? rd_idx_q + 1'b1 : rd_idx_q;
    rd_pend_d    = rd_en;
    skid_full_d  = skid_full_q;
    skid_data_d  = skid_data_q;
    emit_idx_d   = emit_idx_q;
    data_d       = data_q;
    bin_d        = bin_q;
    start_d      = 1'b0;
    last_d       = 1'b0;
    emit         = 1'b0;
    frame_done_d = (state_q == DRAIN) && last_q;
    overrun_d    = bus.i_fft_done && busy;

    // Reads stop during a stall, so at most one word lands in the skid.
    if (bus.i_stall) begin
      if (rd_pend_q) begin
        skid_full_d = 1'b1;
        skid_data_d = bus.i_rd_data;
      end
    end else if (skid_full_q) begin
      skid_full_d = 1'b0;
      data_d      = skid_data_q;
      emit        = 1'b1;
    end else if (rd_pend_q) begin
      data_d = bus.i_rd_data;
      emit   = 1'b1;
    end

    if (emit) begin
      start_d    = 1'b1;
      bin_d      = emit_idx_q;
      last_d     = (emit_idx_q == LAST_BIN);
      emit_idx_d = emit_idx_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx_q     <= '0;
      rd_pend_q    <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_data_q  <= '0;
      emit_idx_q   <= '0;
      data_q       <= '0;
      bin_q        <= '0;
      start_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rd_idx_q     <= rd_idx_d;
      rd_pend_q    <= rd_pend_d;
      skid_full_q  <= skid_full_d;
      skid_data_q  <= skid_data_d;
      emit_idx_q   <= emit_idx_d;
      data_q       <= data_d;
      bin_q        <= bin_d;
      start_q      <= start_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.o_rd_en       = rd_en;
  assign bus.o_rd_addr     = rd_addr;
  assign bus.o_fft_complex = data_q;
  assign bus.o_start       = start_q;
  assign bus.o_bin_index   = bin_q;
  assign bus.o_last        = last_q;
  assign bus.o_busy        = busy;
  assign bus.o_frame_done  = frame_done_q;
  assign bus.o_overrun     = overrun_q;
endmodule

// File: tb/tb_fft_bin_streamer.sv
// Directed bench for fft_bin_streamer: cycle table for one clean frame, then stall,
// overrun, back-to-back and mid-frame reset sequences against a RAM model {addr*100, -addr}.
module tb_fft_bin_streamer;
  localparam int DW   = 24;
  localparam int NP   = 16;
  localparam int AW   = 4;
  localparam int HALF = NP / 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_bin_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fft_bin_streamer #(.DATA_WIDTH(DW), .FFT_POINTS(NP), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic int bitrev4(input int a);
    logic [3:0] v;
    v = 4'(a);
    return int'({v[0], v[1], v[2], v[3]});
  endfunction

  function automatic int map_addr(input int k);
`ifdef FFT_BIT_REVERSE_EN
    return bitrev4(k);
`else
    return k;
`endif
  endfunction

  function automatic logic [2*DW-1:0] ram_word(input int a);
    logic [DW-1:0] re, im;
    re = DW'(a * 100);
    im = DW'(-a);
    return {re, im};
  endfunction

  function automatic logic [2*DW-1:0] exp_data(input int k);
    return ram_word(map_addr(k));
  endfunction

  // One-cycle-latency RAM
  always @(posedge clk)
    if (bus.o_rd_en) bus.i_rd_data <= ram_word(int'(bus.o_rd_addr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit fd, input bit st);
    bus.i_fft_done = fd;
    bus.i_stall    = st;
  endtask

  typedef struct {
    bit fd; bit st;
    bit rd; int idx;
    bit start; int bin; bit last; bit busy; bit fdone; bit ovr;
  } vec_t;

  function automatic vec_t mk(input bit fd, input bit st, input bit rd, input int idx,
                              input bit start, input int bin, input bit last,
                              input bit busy, input bit fdone, input bit ovr);
    vec_t v;
    v.fd = fd; v.st = st; v.rd = rd; v.idx = idx; v.start = start; v.bin = bin;
    v.last = last; v.busy = busy; v.fdone = fdone; v.ovr = ovr;
    return v;
  endfunction

  // Scoreboard state shared by sample()/run_frame()
  int exp_next, nbins, fdone_cnt, ovr_cnt, idle_run, gap3;
  bit s_start;
  int s_bin;

  task automatic sample();
    @(negedge clk);
    s_start = bus.o_start;
    s_bin   = int'(bus.o_bin_index);
    if (bus.o_start) begin
      check("bin_order", 64'(bus.o_bin_index), 64'(exp_next));
      check("bin_data", 64'(bus.o_fft_complex), 64'(exp_data(exp_next)));
      check("last_flag", 64'(bus.o_last), 64'(exp_next == HALF - 1));
      if (exp_next == 3) gap3 = idle_run;
      idle_run = 0;
      nbins++;
      exp_next++;
    end else begin
      idle_run++;
    end
    if (bus.o_frame_done) begin
      fdone_cnt++;
      check("fdone_busy_low", 64'(bus.o_busy), 64'd0);
    end
    if (bus.o_overrun) ovr_cnt++;
  endtask

  // Starts a frame in the current cycle; returns in the o_frame_done cycle with inputs idle.
  task automatic run_frame(input string tag, input int stall_bin, input int ovr_at);
    int  stall_left = 0;
    bit  stall_used = 0;
    int  first_c    = -1;
    bit  done       = 0;
    exp_next = 0; nbins = 0; fdone_cnt = 0; ovr_cnt = 0; idle_run = 0; gap3 = -1;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 40 && !done; c++) begin
      sample();
      if (s_start && first_c < 0) first_c = c;
      if (fdone_cnt != 0) begin
        done = 1;
      end else begin
        if (s_start && stall_bin >= 0 && !stall_used && s_bin == stall_bin) begin
          stall_left = 3;
          stall_used = 1;
        end
        drive(c + 1 == ovr_at, stall_left > 0);
        if (stall_left > 0) stall_left--;
      end
    end
    check({tag, "_first_latency"}, 64'(first_c), 64'd2);
    check({tag, "_bins"}, 64'(nbins), 64'(HALF));
    check({tag, "_frame_done"}, 64'(fdone_cnt), 64'd1);
    check({tag, "_overrun"}, 64'(ovr_cnt), 64'(ovr_at > 0));
    if (stall_bin >= 0) check({tag, "_stall_gap"}, 64'(gap3), 64'd3);
  endtask

  vec_t tbl[13];

  initial begin
    bit got4;

    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 2, 1, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 3, 1, 1, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 1, 4, 1, 2, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 5, 1, 3, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 6, 1, 4, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 7, 1, 5, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 6, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 7, 1, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 7, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 7, 0, 0, 0, 0);

    drive(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_start", 64'(bus.o_start), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_rd_en", 64'(bus.o_rd_en), 64'd0);
    check("rst_data", 64'(bus.o_fft_complex), 64'd0);
    check("rst_frame_done", 64'(bus.o_frame_done), 64'd0);
    reset = 1'b1;

    // Clean frame, cycle by cycle (stall in IDLE must not block the start)
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].fd, tbl[i].st);
      #1;
      check($sformatf("r%0d_rd_en", i), 64'(bus.o_rd_en), 64'(tbl[i].rd));
      check($sformatf("r%0d_rd_addr", i), 64'(bus.o_rd_addr), 64'(map_addr(tbl[i].idx)));
      check($sformatf("r%0d_start", i), 64'(bus.o_start), 64'(tbl[i].start));
      check($sformatf("r%0d_bin", i), 64'(bus.o_bin_index), 64'(tbl[i].bin));
      check($sformatf("r%0d_data", i), 64'(bus.o_fft_complex), 64'(exp_data(tbl[i].bin)));
      check($sformatf("r%0d_last", i), 64'(bus.o_last), 64'(tbl[i].last));
      check($sformatf("r%0d_busy", i), 64'(bus.o_busy), 64'(tbl[i].busy));
      check($sformatf("r%0d_frame_done", i), 64'(bus.o_frame_done), 64'(tbl[i].fdone));
      check($sformatf("r%0d_overrun", i), 64'(bus.o_overrun), 64'(tbl[i].ovr));
    end

    run_frame("nostall", -1, 0);
    run_frame("stall", 2, 0);
    run_frame("overrun", -1, 4);
    run_frame("b2b", -1, 0);

    // Reset after bin 4 of a frame
    exp_next = 0; nbins = 0; fdone_cnt = 0; ovr_cnt = 0; idle_run = 0;
    got4 = 0;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 20 && !got4; c++) begin
      sample();
      if (s_start && s_bin == 4) got4 = 1;
      else drive(1'b0, 1'b0);
    end
    drive(1'b0, 1'b0);
    check("rst_mid_reached_bin4", 64'(got4), 64'd1);
    reset = 1'b0;
    #1;
    check("rstm_rd_en", 64'(bus.o_rd_en), 64'd0);
    check("rstm_rd_addr", 64'(bus.o_rd_addr), 64'd0);
    check("rstm_data", 64'(bus.o_fft_complex), 64'd0);
    check("rstm_start", 64'(bus.o_start), 64'd0);
    check("rstm_bin", 64'(bus.o_bin_index), 64'd0);
    check("rstm_last", 64'(bus.o_last), 64'd0);
    check("rstm_busy", 64'(bus.o_busy), 64'd0);
    check("rstm_frame_done", 64'(bus.o_frame_done), 64'd0);
    check("rstm_overrun", 64'(bus.o_overrun), 64'd0);
    fdone_cnt = 0;
    sample();
    sample();
    reset = 1'b1;
    sample();
    sample();
    check("rstm_no_frame_done", 64'(fdone_cnt), 64'd0);

    run_frame("restart", -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_bin_streamer.md
Name: fft_bin_streamer

Overview:
- Reads a completed FFT frame from the FFT result RAM and streams complex bins, one per clock, into the magnitude approximator.
- Drives the `{real, imag}` bus and the `i_start` strobe that the magnitude approximator consumes.
- Emits only the non-redundant half of the spectrum (bins 0..FFT_POINTS/2-1).
- Sits between the FFT core's result RAM and the magnitude stage; supports a downstream stall.

Parameters:
- DATA_WIDTH, 24: width of each of real and imag (signed two's complement).
- FFT_POINTS, 1024: FFT length; power of two, >=4.
- ADDR_WIDTH, $clog2(FFT_POINTS): RAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_fft_done  in  1  one-cycle pulse: RAM holds a complete frame.
- i_stall  in  1  downstream hold; no new bin is emitted while high.
- o_rd_en  out  1  RAM read enable.
- o_rd_addr  out  ADDR_WIDTH  RAM read address.
- i_rd_data  in  2*DATA_WIDTH  RAM read data `{real, imag}`, valid on the edge after an o_rd_en cycle (1-cycle latency).
- o_fft_complex  out  2*DATA_WIDTH  bin data `{real[2*DW-1:DW], imag[DW-1:0]}`.
- o_start  out  1  one cycle per emitted bin; o_fft_complex is valid in that cycle.
- o_bin_index  out  ADDR_WIDTH-1  natural bin number of o_fft_complex.
- o_last  out  1  high with o_start for bin FFT_POINTS/2-1.
- o_busy  out  1  frame in progress.
- o_frame_done  out  1  one-cycle pulse the cycle after o_last.
- o_overrun  out  1  one-cycle pulse: i_fft_done arrived while busy.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; skid register empty.
- States:
  - IDLE -> READ on an edge sampling i_fft_done=1; o_busy=1 from that edge.
  - READ: o_rd_en = (state==READ) & ~i_stall (combinational). o_rd_addr holds the read index and advances by 1 at each edge where o_rd_en=1. After the edge issuing index FFT_POINTS/2-1, go to DRAIN.
  - DRAIN -> IDLE at the edge where the last bin is emitted (o_last). At that same edge: o_busy<=0, o_frame_done<=1 for one cycle.
- Emission, at each edge:
  - If i_stall=1: o_start<=0; o_fft_complex and o_bin_index hold. Returned RAM data, if any, goes into a 1-entry skid register. At most one return can occur under stall, because o_rd_en is low during stall.
  - If i_stall=0: emit the skid entry if full (and clear the skid), else the returned data if present. Either case sets o_start<=1. If neither, o_start<=0.
- Latency, no stall: i_fft_done sampled at edge E0 -> o_rd_en/addr 0 during E0..E1 -> data returned at E2 -> first o_start high after E2. Bins then follow on consecutive cycles; o_last after E2+FFT_POINTS/2-1.
- Bin order is strictly increasing; no bin is dropped or duplicated under any stall pattern.
- Overrun: i_fft_done=1 while o_busy=1 is ignored and produces o_overrun=1 the next cycle. i_fft_done sampled during the o_frame_done cycle is accepted (state already IDLE).
- Reset mid-frame: immediate abort. Outputs and state return to reset values, the skid is cleared, and no o_frame_done is emitted.
- i_stall in IDLE has no effect.

Optional Feature:
- Macro FFT_BIT_REVERSE_EN.
- Defined: the RAM holds results in bit-reversed order. o_rd_addr = bit-reverse of the natural index over ADDR_WIDTH bits; o_bin_index stays natural.
- Undefined: o_rd_addr = natural index.
- Timing and handshake are identical in both builds.

Test Plan:
- Bench setup: FFT_POINTS=16, DATA_WIDTH=24. RAM model returns `{addr*100, -addr}`.
- Single frame, no stall: pulse i_fft_done -> 8 consecutive o_start. Bin k carries `{k*100, -k}`; o_bin_index 0..7; o_last with bin 7; o_frame_done next cycle; o_busy low with it.
- Stall: hold i_stall high for 3 cycles starting while bin 2 is emitting -> o_start low 3 cycles. Bin 3 `{300, -3}` is emitted first after release; total 8 bins, none repeated.
- Overrun: second i_fft_done 4 cycles into the frame -> o_overrun pulses once; the frame completes normally with 8 bins.
- Back-to-back: i_fft_done high in the o_frame_done cycle -> second frame starts; first o_start 3 edges later.
- Reset mid-frame: reset=0 after bin 4 -> all outputs 0, no o_frame_done. A new i_fft_done restarts at bin 0.
- FFT_BIT_REVERSE_EN defined -> o_rd_addr sequence 0,8,4,12,2,10,6,14. Bin k data equals `{bitrev(k)*100, -bitrev(k)}`; o_bin_index 0..7.
